// File: rtl/pe_pbs_pkg.sv
// Shared sizing parameters for the PBS processing elements.
// Every block in the PBS front end sizes itself from these values.
package pe_pbs_pkg;
  localparam int BATCH_PBS_NB = 9;
  localparam int TOTAL_PBS_NB = 27;
  localparam int GRAM_NB      = 3;
  localparam int ID_W         = 16;
  localparam int TIMEOUT      = 64;
endpackage

// File: rtl/pep_batch_former_pkg.sv
// Widths, batch buffer entry, FSM states and GRAM-bank helper for pep_batch_former.
// Derived widths follow the shared sizing parameters.
package pep_batch_former_pkg;
  import pe_pbs_pkg::*;

  localparam int PID_W  = $clog2(TOTAL_PBS_NB);
  localparam int BCNT_W = $clog2(BATCH_PBS_NB + 1);
  localparam int GID_W  = $clog2(GRAM_NB);
  localparam int TMR_W  = $clog2(TIMEOUT);

  typedef struct packed {
    logic [PID_W-1:0] pid;
    logic [GID_W-1:0] gid;
    logic [ID_W-1:0]  id;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_SEND
  } state_e;

  function automatic logic [GID_W-1:0] gid_of(input logic [PID_W-1:0] pid);
    return GID_W'(int'(pid) % GRAM_NB);
  endfunction
endpackage

// File: rtl/pep_batch_former_if.sv
// Request, batch command and completion signals of pep_batch_former.
// The slave modport is the batch former; the master modport is its environment.
interface pep_batch_former_if;
  import pe_pbs_pkg::*;
  import pep_batch_former_pkg::*;

  logic                           in_vld;
  logic                           in_rdy;
  logic [ID_W-1:0]                in_id;
  logic                           flush;
  logic                           out_vld;
  logic                           out_rdy;
  logic [BCNT_W-1:0]              out_pbs_nb;
  logic [BATCH_PBS_NB*PID_W-1:0]  out_pid;
  logic [BATCH_PBS_NB*ID_W-1:0]   out_id;
  logic [BATCH_PBS_NB*GID_W-1:0]  out_gid;
  logic                           done_vld;
  logic [PID_W-1:0]               done_pid;
  logic [PID_W:0]                 free_cnt;
  logic                           err_double_free;

  modport master (
    output in_vld, in_id, flush, out_rdy, done_vld, done_pid,
    input  in_rdy, out_vld, out_pbs_nb, out_pid, out_id, out_gid, free_cnt, err_double_free
  );

  modport slave (
    input  in_vld, in_id, flush, out_rdy, done_vld, done_pid,
    output in_rdy, out_vld, out_pbs_nb, out_pid, out_id, out_gid, free_cnt, err_double_free
  );
endinterface

// File: rtl/pep_slot_pool.sv
// PBS slot pool: free bitmap, in-order allocation ring, free counter and
// detection of completions for slots that are already free.
module pep_slot_pool
  import pe_pbs_pkg::*, pep_batch_former_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_en,
  input  logic             free_vld,
  input  logic [PID_W-1:0] free_pid,
  output logic             alloc_rdy,
  output logic [PID_W-1:0] alloc_pid,
  output logic [PID_W:0]   free_cnt,
  output logic             err
);

  logic [TOTAL_PBS_NB-1:0] slot_free;
  logic [PID_W-1:0]        alloc_ptr;
  logic                    free_in_range;
  logic                    free_hit;
  logic                    free_dup;

  // Only the ring head may be handed out, so a busy head stalls allocation.
  assign alloc_rdy     = slot_free[alloc_ptr];
  assign alloc_pid     = alloc_ptr;
  assign free_in_range = free_pid < PID_W'(TOTAL_PBS_NB);
  assign free_hit      = free_vld && free_in_range && !slot_free[free_pid];
  assign free_dup      = free_vld && free_in_range && slot_free[free_pid];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_free <= '1;
      alloc_ptr <= '0;
      free_cnt  <= (PID_W+1)'(TOTAL_PBS_NB);
      err       <= 1'b0;
    end else begin
      err <= free_dup;
      if (alloc_en) begin
        slot_free[alloc_ptr] <= 1'b0;
        alloc_ptr <= (alloc_ptr == PID_W'(TOTAL_PBS_NB - 1)) ? '0 : alloc_ptr + PID_W'(1);
      end
      if (free_hit) begin
        slot_free[free_pid] <= 1'b1;
      end
      case ({free_hit, alloc_en})
        2'b10:   free_cnt <= free_cnt + (PID_W+1)'(1);
        2'b01:   free_cnt <= free_cnt - (PID_W+1)'(1);
        default: free_cnt <= free_cnt;
      endcase
    end
  end

endmodule

// File: rtl/pep_batch_former.sv
// Groups single-PBS requests into batches of up to BATCH_PBS_NB, allocating a
// slot per request and launching on full batch, idle timeout or flush.
module pep_batch_former
  import pe_pbs_pkg::*, pep_batch_former_pkg::*;
(
  input logic                 clk,
  input logic                 s_rst_n,
  pep_batch_former_if.slave   bus
);

  state_e            state, state_nxt;
  logic [BCNT_W-1:0] fill_cnt, fill_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt;
  entry_t            ent [BATCH_PBS_NB];
  logic              run;
  logic              alloc_rdy;
  logic [PID_W-1:0]  alloc_pid;
  logic              accept;

  // run keeps in_rdy low while reset is held and until the first clock after it.
  assign bus.in_rdy = run && (state != ST_SEND) && alloc_rdy;
  assign accept     = bus.in_vld && bus.in_rdy;

  pep_slot_pool u_pool (
    .clk       (clk),
    .rst_n     (s_rst_n),
    .alloc_en  (accept),
    .free_vld  (bus.done_vld),
    .free_pid  (bus.done_pid),
    .alloc_rdy (alloc_rdy),
    .alloc_pid (alloc_pid),
    .free_cnt  (bus.free_cnt),
    .err       (bus.err_double_free)
  );

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state    <= ST_IDLE;
      fill_cnt <= '0;
      timer    <= '0;
      run      <= 1'b0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_nxt;
      timer    <= timer_nxt;
      run      <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_cnt;
    timer_nxt = timer;
    case (state)
      ST_IDLE: begin
        timer_nxt = '0;
        if (accept) begin
          fill_nxt  = fill_cnt + BCNT_W'(1);
          state_nxt = (fill_nxt == BCNT_W'(BATCH_PBS_NB)) ? ST_SEND : ST_FILL;
        end
      end
      ST_FILL: begin
        if (accept) begin
          fill_nxt  = fill_cnt + BCNT_W'(1);
          timer_nxt = '0;
        end else if (timer != TMR_W'(TIMEOUT - 1)) begin
          timer_nxt = timer + TMR_W'(1);
        end
        // Launch decision uses the post-accept count and the pre-update timer.
        if (fill_nxt == BCNT_W'(BATCH_PBS_NB) || timer == TMR_W'(TIMEOUT - 1) || bus.flush) begin
          state_nxt = ST_SEND;
          timer_nxt = '0;
        end
      end
      ST_SEND: begin
        if (bus.out_rdy) begin
          state_nxt = ST_IDLE;
          fill_nxt  = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int k = 0; k < BATCH_PBS_NB; k++) begin
        ent[k] <= '0;
      end
    end else if (accept) begin
      ent[fill_cnt] <= '{pid: alloc_pid, gid: gid_of(alloc_pid), id: bus.in_id};
    end
  end

  // Entries at or beyond the batch count are forced to zero on the bus.
  always_comb begin
    bus.out_vld    = (state == ST_SEND);
    bus.out_pbs_nb = (state == ST_SEND) ? fill_cnt : '0;
    bus.out_pid    = '0;
    bus.out_id     = '0;
    bus.out_gid    = '0;
    for (int k = 0; k < BATCH_PBS_NB; k++) begin
      if (state == ST_SEND && BCNT_W'(k) < fill_cnt) begin
        bus.out_pid[k*PID_W +: PID_W] = ent[k].pid;
        bus.out_id[k*ID_W +: ID_W]    = ent[k].id;
        bus.out_gid[k*GID_W +: GID_W] = ent[k].gid;
      end
    end
  end

endmodule

// File: tb/tb_pep_batch_former.sv
// Directed self-checking bench for pep_batch_former: full batches, timeout,
// flush, slot exhaustion with wrap, backpressure, double free and reset.
module tb_pep_batch_former;
  import pe_pbs_pkg::*;
  import pep_batch_former_pkg::*;

  logic clk;
  logic s_rst_n;
  int   checks;
  int   failures;
  logic mon_en;
  int   batch_q[$];

  pep_batch_former_if bus();

  pep_batch_former dut (
    .clk     (clk),
    .s_rst_n (s_rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  always @(negedge clk) begin
    if (mon_en && bus.out_vld && bus.out_rdy) batch_q.push_back(int'(bus.out_pbs_nb));
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PID_W-1:0] pid_at(input int k);
    return bus.out_pid[k*PID_W +: PID_W];
  endfunction

  function automatic logic [ID_W-1:0] id_at(input int k);
    return bus.out_id[k*ID_W +: ID_W];
  endfunction

  function automatic logic [GID_W-1:0] gid_at(input int k);
    return bus.out_gid[k*GID_W +: GID_W];
  endfunction

  task automatic doReset();
    s_rst_n      = 1'b0;
    bus.in_vld   = 1'b0;
    bus.in_id    = '0;
    bus.flush    = 1'b0;
    bus.out_rdy  = 1'b1;
    bus.done_vld = 1'b0;
    bus.done_pid = '0;
    repeat (2) @(negedge clk);
    s_rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Called on a negedge; returns on the negedge after the accepting posedge with in_vld still high.
  task automatic applyStimulus(input logic [ID_W-1:0] id);
    int n;
    n = 0;
    bus.in_vld = 1'b1;
    bus.in_id  = id;
    while (!bus.in_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_rdy) begin
      checkOutput("req_rdy_timeout", 64'(bus.in_rdy), 64'd1);
      bus.in_vld = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  initial begin
    int   n;
    logic seen, zero_ok, stable, rdy_seen, vld_low;
    logic [BCNT_W-1:0]             snap_nb;
    logic [BATCH_PBS_NB*PID_W-1:0] snap_pid;
    logic [BATCH_PBS_NB*ID_W-1:0]  snap_id;
    logic [BATCH_PBS_NB*GID_W-1:0] snap_gid;

    checks   = 0;
    failures = 0;
    mon_en   = 1'b0;

    // Reset state
    doReset();
    checkOutput("rst_out_vld", 64'(bus.out_vld), 64'd0);
    checkOutput("rst_free_cnt", 64'(bus.free_cnt), 64'd27);
    checkOutput("rst_err", 64'(bus.err_double_free), 64'd0);
    checkOutput("rst_pbs_nb", 64'(bus.out_pbs_nb), 64'd0);
    checkOutput("rst_in_rdy", 64'(bus.in_rdy), 64'd1);

    // Full batch of 9 back-to-back requests
    doReset();
    for (int i = 0; i < 9; i++) begin
      if (i == 8) checkOutput("full_vld_early", 64'(bus.out_vld), 64'd0);
      applyStimulus(ID_W'(16'h100 + i));
    end
    bus.in_vld = 1'b0;
    checkOutput("full_out_vld", 64'(bus.out_vld), 64'd1);
    checkOutput("full_pbs_nb", 64'(bus.out_pbs_nb), 64'd9);
    checkOutput("full_free_cnt", 64'(bus.free_cnt), 64'd18);
    checkOutput("full_in_rdy", 64'(bus.in_rdy), 64'd0);
    for (int k = 0; k < 9; k++) begin
      checkOutput($sformatf("full_pid%0d", k), 64'(pid_at(k)), 64'(k));
      checkOutput($sformatf("full_gid%0d", k), 64'(gid_at(k)), 64'(k % 3));
      checkOutput($sformatf("full_id%0d", k), 64'(id_at(k)), 64'(16'h100 + k));
    end
    @(negedge clk);
    checkOutput("full_back_idle", 64'(bus.out_vld), 64'd0);

    // Partial batch launched by idle timeout
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(ID_W'(16'h200 + i));
    bus.in_vld = 1'b0;
    n = 0;
    while (!bus.out_vld && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tmo_seen", 64'(bus.out_vld), 64'd1);
    checkOutput("tmo_cycles_63_or_64", 64'(n == 63 || n == 64), 64'd1);
    checkOutput("tmo_pbs_nb", 64'(bus.out_pbs_nb), 64'd4);
    checkOutput("tmo_pid3", 64'(pid_at(3)), 64'd3);
    checkOutput("tmo_id3", 64'(id_at(3)), 64'h203);
    zero_ok = 1'b1;
    for (int k = 4; k < 9; k++) begin
      if (pid_at(k) != '0 || id_at(k) != '0 || gid_at(k) != '0) zero_ok = 1'b0;
    end
    checkOutput("tmo_tail_zero", 64'(zero_ok), 64'd1);
    @(negedge clk);

    // Flush of a partial batch, then flush while idle
    doReset();
    applyStimulus(16'h300);
    applyStimulus(16'h301);
    bus.in_vld = 1'b0;
    bus.flush  = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checkOutput("flush_out_vld", 64'(bus.out_vld), 64'd1);
    checkOutput("flush_pbs_nb", 64'(bus.out_pbs_nb), 64'd2);
    checkOutput("flush_id1", 64'(id_at(1)), 64'h301);
    checkOutput("flush_gid1", 64'(gid_at(1)), 64'd1);
    @(negedge clk);
    bus.flush = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= bus.out_vld;
    end
    bus.flush = 1'b0;
    checkOutput("flush_idle_no_vld", 64'(seen), 64'd0);

    // Exhaust all 27 slots, head-of-line stall, then wrap to pid 0
    doReset();
    batch_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 27; i++) applyStimulus(ID_W'(16'h400 + i));
    bus.in_vld = 1'b0;
    @(negedge clk);
    mon_en = 1'b0;
    checkOutput("exh_batches", 64'(batch_q.size()), 64'd3);
    for (int b = 0; b < 3; b++) begin
      if (b < batch_q.size()) checkOutput($sformatf("exh_batch%0d_nb", b), 64'(batch_q[b]), 64'd9);
    end
    checkOutput("exh_free_cnt", 64'(bus.free_cnt), 64'd0);
    bus.in_vld = 1'b1;
    bus.in_id  = 16'h428;
    checkOutput("exh_in_rdy", 64'(bus.in_rdy), 64'd0);
    @(negedge clk);
    checkOutput("exh_in_rdy_hold", 64'(bus.in_rdy), 64'd0);
    bus.done_vld = 1'b1;
    bus.done_pid = 5'd0;
    @(negedge clk);
    bus.done_vld = 1'b0;
    checkOutput("wrap_in_rdy", 64'(bus.in_rdy), 64'd1);
    checkOutput("wrap_free_cnt", 64'(bus.free_cnt), 64'd1);
    @(negedge clk);
    bus.in_vld = 1'b0;
    bus.flush  = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checkOutput("wrap_out_vld", 64'(bus.out_vld), 64'd1);
    checkOutput("wrap_pbs_nb", 64'(bus.out_pbs_nb), 64'd1);
    checkOutput("wrap_pid0", 64'(pid_at(0)), 64'd0);
    checkOutput("wrap_id0", 64'(id_at(0)), 64'h428);
    checkOutput("wrap_free_cnt0", 64'(bus.free_cnt), 64'd0);
    @(negedge clk);

    // Backpressure held for 10 cycles in SEND
    doReset();
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 9; i++) applyStimulus(ID_W'(16'h500 + i));
    bus.in_id = 16'h5ff;
    snap_nb  = bus.out_pbs_nb;
    snap_pid = bus.out_pid;
    snap_id  = bus.out_id;
    snap_gid = bus.out_gid;
    stable   = 1'b1;
    rdy_seen = 1'b0;
    vld_low  = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_pbs_nb != snap_nb || bus.out_pid != snap_pid ||
          bus.out_id != snap_id || bus.out_gid != snap_gid) stable = 1'b0;
      rdy_seen |= bus.in_rdy;
      vld_low  |= !bus.out_vld;
    end
    checkOutput("bp_out_stable", 64'(stable), 64'd1);
    checkOutput("bp_in_rdy_low", 64'(rdy_seen), 64'd0);
    checkOutput("bp_out_vld_held", 64'(vld_low), 64'd0);
    checkOutput("bp_id8", 64'(id_at(8)), 64'h508);
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_vld", 64'(bus.out_vld), 64'd0);
    checkOutput("bp_release_rdy", 64'(bus.in_rdy), 64'd1);

    // Double free, out-of-range free, then reset mid-FILL
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(ID_W'(16'h600 + i));
    bus.in_vld   = 1'b0;
    bus.done_vld = 1'b1;
    bus.done_pid = 5'd5;
    @(negedge clk);
    checkOutput("dfree_first_err", 64'(bus.err_double_free), 64'd0);
    checkOutput("dfree_first_cnt", 64'(bus.free_cnt), 64'd22);
    @(negedge clk);
    bus.done_vld = 1'b0;
    checkOutput("dfree_second_err", 64'(bus.err_double_free), 64'd1);
    checkOutput("dfree_second_cnt", 64'(bus.free_cnt), 64'd22);
    @(negedge clk);
    checkOutput("dfree_err_pulse", 64'(bus.err_double_free), 64'd0);
    bus.done_vld = 1'b1;
    bus.done_pid = 5'd30;
    @(negedge clk);
    bus.done_vld = 1'b0;
    checkOutput("oor_free_err", 64'(bus.err_double_free), 64'd0);
    checkOutput("oor_free_cnt", 64'(bus.free_cnt), 64'd22);
    checkOutput("mid_fill_no_vld", 64'(bus.out_vld), 64'd0);
    s_rst_n = 1'b0;
    #1;
    checkOutput("async_rst_vld", 64'(bus.out_vld), 64'd0);
    checkOutput("async_rst_free_cnt", 64'(bus.free_cnt), 64'd27);
    checkOutput("async_rst_in_rdy", 64'(bus.in_rdy), 64'd0);
    @(negedge clk);
    s_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_pbs_nb", 64'(bus.out_pbs_nb), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
